data_mem_responder: RTL

//  Memory-side responder for the core's req/gnt/rvalid data bus (data_req_o..data_rdata_i of the core wrapper).

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Core data bus between the requester (master) and data_mem_responder (slave):
// req/gnt request channel with back-pressure input and an in-order rvalid response channel.
interface data_mem_responder_if;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i, stall_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i, stall_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word memory behind a req/gnt/rvalid bus: combinational grant, in-order response ReadLatency cycles later.
// Back-pressure: stall_i or MaxOutstanding in-flight transactions hold gnt_o low; rvalid_o cannot be stalled.
module data_mem_responder #(
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int          MemWords       = 256,
  parameter int          ReadLatency    = 1,
  parameter int          MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_responder_if.slave  bus
);

  localparam int          AddrW     = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int          CntW      = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] SpanBytes = 33'(MemWords) * 33'd4;

  generate
    if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
      $error("data_mem_responder: ReadLatency must be in 1..4");
    end
    if (MemWords < 1 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_depth
      $error("data_mem_responder: MemWords must be a power of 2");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > ReadLatency + 1) begin : g_bad_outstanding
      $error("data_mem_responder: MaxOutstanding must be in 1..ReadLatency+1");
    end
  endgenerate

  logic [31:0] mem_q [MemWords];

  logic [31:0]      offset;
  logic             legal;
  logic [AddrW-1:0] word;

  logic             gnt;
  logic             rvalid;
  logic             mem_we;
  logic [31:0]      mem_wdata;

  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [ReadLatency-1:0]       valid_q, valid_d;
  logic [ReadLatency-1:0]       err_q,   err_d;
  logic [ReadLatency-1:0][31:0] rdata_q, rdata_d;

  // Unsigned range check on the un-wrapped offset; the >= guard rejects addresses below the base.
  always_comb begin
    offset = bus.addr_i - BaseAddr;
    legal  = (bus.addr_i >= BaseAddr) && ({1'b0, offset} < SpanBytes);
    word   = offset[AddrW+1:2];
  end

  assign rvalid = valid_q[ReadLatency-1];

  // A response leaving this cycle frees a slot, so a saturated counter can still grant.
  always_comb begin
    gnt = bus.req_i & ~bus.stall_i & ~rst_i &
          ((cnt_q < CntW'(MaxOutstanding)) | rvalid);
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({gnt, rvalid})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    mem_we    = gnt & bus.we_i & legal;
    mem_wdata = mem_q[word];
    for (int n = 0; n < 4; n++) begin
      if (bus.be_i[n]) begin
        mem_wdata[8*n +: 8] = bus.wdata_i[8*n +: 8];
      end
    end
  end

  // Stage 0 captures the response at the grant edge; writes and errors carry zero data.
  always_comb begin
    valid_d    = valid_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    valid_d[0] = gnt;
    err_d[0]   = gnt & ~legal;
    rdata_d[0] = (gnt & ~bus.we_i & legal) ? mem_q[word] : 32'h0;
    for (int i = 1; i < ReadLatency; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      rdata_d[i] = rdata_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      valid_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[word] <= mem_wdata;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rvalid ? rdata_q[ReadLatency-1] : 32'h0;
  assign bus.err_o    = rvalid ? err_q[ReadLatency-1]   : 1'b0;

endmodule
